// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster geometry and coordinate width
package vga_timing_pkg;
  localparam int COORD_W = 10;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP = 33;
  localparam logic DEF_SYNC_POL = 1'b0;
  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END = DEF_V_SYNC_START + DEF_V_SYNC - 1;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_sync_counter.sv
// sync_counter: wrapping counter with enable, terminal count and sync-window decode
module sync_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL,
  parameter int unsigned SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned SYNC_END = DEF_H_SYNC_END
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  output coord_t cnt_o,
  output logic   tc_o,
  output logic   sync_o
);
  coord_t cnt_q, cnt_d;
  assign tc_o = cnt_q == COORD_W'(TOTAL - 1);
  assign sync_o = cnt_q >= COORD_W'(SYNC_START) && cnt_q <= COORD_W'(SYNC_END);
  assign cnt_o = cnt_q;
  always_comb cnt_d = !en_i ? cnt_q : tc_o ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator; define VGA_PIX_DIV2_EN to advance every second clk
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic         clk,
  input  logic         reset,
  output coord_t       pix_x,
  output coord_t       pix_y,
  output logic         video_on,
  output logic         pix_tick,
  output logic         frame_tick,
  input  logic [2:0]   graph_rgb,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [2:0]   rgb_out
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic h_tc, v_tc, h_sync, v_sync;
  logic hsync_q, vsync_q, de_q, frame_tick_q;
  logic [2:0] rgb_q;
`ifdef VGA_PIX_DIV2_EN
  logic div_q;
  always_ff @(posedge clk) div_q <= reset ? 1'b0 : ~div_q;
  assign pix_tick = div_q;
`else
  assign pix_tick = 1'b1;
`endif
  sync_counter #(
    .TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC - 1)
  ) u_h (
    .clk(clk), .reset(reset), .en_i(pix_tick), .cnt_o(pix_x), .tc_o(h_tc), .sync_o(h_sync)
  );
  sync_counter #(
    .TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC - 1)
  ) u_v (
    .clk(clk), .reset(reset), .en_i(pix_tick & h_tc), .cnt_o(pix_y), .tc_o(v_tc), .sync_o(v_sync)
  );
  assign video_on = pix_x < COORD_W'(H_ACTIVE) && pix_y < COORD_W'(V_ACTIVE);
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q <= 1'b0;
      rgb_q <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= pix_tick & h_tc & v_tc;
      if (pix_tick) begin
        hsync_q <= h_sync ? SYNC_POL : ~SYNC_POL;
        vsync_q <= v_sync ? SYNC_POL : ~SYNC_POL;
        de_q <= video_on;
        rgb_q <= video_on ? graph_rgb : '0;
      end
    end
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de = de_q;
  assign rgb_out = rgb_q;
  assign frame_tick = frame_tick_q;
endmodule
